// File: rtl/wb_regfile_hilo.sv
// Write-back sink: 32-entry GPR file with same-cycle write-through read ports,
// the HI/LO register pair, and a retired-write counter for debug.
module wb_regfile_hilo #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [31:0]       retire_cnt
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Read priority: reset, disabled port, r0, bypass of the in-flight write, stored value.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              rst_v,
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic              we_v,
    input logic [ADDR_W-1:0] waddr_v,
    input logic [DATA_W-1:0] wdata_v,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] res;
    res = '0;
    if (rst_v || !en || addr == '0)
      res = '0;
    else if (we_v && waddr_v == addr)
      res = wdata_v;
    else
      res = stored;
    return res;
  endfunction

  always_comb begin
    rdata1 = read_mux(rst, re1, raddr1, we, waddr, wdata, regs[raddr1]);
    rdata2 = read_mux(rst, re2, raddr2, we, waddr, wdata, regs[raddr2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      hi_o       <= '0;
      lo_o       <= '0;
      retire_cnt <= '0;
    end else begin
      if (we && waddr != '0)
        regs[waddr] <= wdata;
      if (whilo) begin
        hi_o <= hi_i;
        lo_o <= lo_i;
      end
      // A dropped r0 write still retires; we and whilo together count once.
      if (we || whilo)
        retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule
